cle_sram_arb: RTL and testbench
===============================

Name: cle_sram_arb

Overview:
- Arbitrates the single-port 1024x8 label SRAM between two requesters.
- Requesters: the connected-component labeling engine (priority requester) and a host readback/debug port (the host uses it to dump or patch labels).
- Fixed priority to the engine, with a starvation-override counter and an engine lock for atomic read-modify-write sequences.
- Sits between both requesters and the SRAM macro; read data is steered back with a 1-cycle valid.

Parameters:
- AW, 10, SRAM address width (32x32 label image).
- DW, 8, SRAM data width.
- STARVE_MAX, 8, cycles the host may wait before it is forced a grant; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- eng_req  input  1  engine access request; held until eng_gnt.
- eng_wen  input  1  engine write enable, active-low (0=write, 1=read).
- eng_lock  input  1  engine lock; suppresses starvation override while high.
- eng_a  input  AW  engine address.
- eng_d  input  DW  engine write data.
- eng_gnt  output  1  engine access issued this cycle.
- eng_q  output  DW  read data (sram_q passthrough).
- eng_qv  output  1  eng_q valid.
- host_req  input  1  host access request; held until host_gnt.
- host_wen  input  1  host write enable, active-low.
- host_a  input  AW  host address.
- host_d  input  DW  host write data.
- host_gnt  output  1  host access issued this cycle.
- host_q  output  DW  read data (sram_q passthrough).
- host_qv  output  1  host_q valid.
- sram_a  output  AW  SRAM address.
- sram_d  output  DW  SRAM write data.
- sram_wen  output  1  SRAM write enable, active-low.
- sram_q  input  DW  SRAM read data, valid the cycle after the address.

Behaviour:
- Reset: starve_cnt=0, rd_owner=NONE, eng_qv=0, host_qv=0. While reset is high, both gnt are 0 and sram_wen=1.
- Grant decision is combinational from req inputs and registered state:
  - force_host = host_req & (starve_cnt==STARVE_MAX) & ~(eng_req & eng_lock).
  - host_gnt = host_req & (~eng_req | force_host).
  - eng_gnt = eng_req & ~host_gnt.
  - eng_gnt and host_gnt are never both 1.
- SRAM mux:
  - Granted requester drives sram_a, sram_d, sram_wen.
  - With no grant: sram_a=0, sram_d=0, sram_wen=1 (no write).
- Writes complete in the grant cycle; no qv is produced for writes.
- Reads:
  - rd_owner register is set to the granted owner when the granted access has wen=1, else NONE.
  - Next cycle: eng_qv=(rd_owner==ENG), host_qv=(rd_owner==HOST).
  - eng_q and host_q always equal sram_q.
  - Back-to-back reads give 1 read per cycle with correct per-owner steering.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments when host_req & ~host_gnt.
  - Saturates at STARVE_MAX.
  - Clears to 0 on host_gnt or when host_req=0.
  - Net effect: a continuously blocked host is granted in its (STARVE_MAX+1)th waiting cycle.
- Lock:
  - While eng_req & eng_lock, the engine always wins; the counter stays saturated.
  - Override fires in the first cycle the lock or eng_req drops.
  - An unbounded lock starves the host by design.
- Host granted while engine requesting: eng_gnt=0 that cycle; the engine holds its request and is granted next cycle (counter now 0).
- Requester contract: a requester must not change a/d/wen while req=1 and gnt=0; the arbiter does not check this.
- Reset mid-read: rd_owner clears asynchronously, so no qv is asserted after reset deasserts.

Decomposition:
- Shared package cle_pkg:
  - CLE_AW=10, CLE_DW=8.
  - Owner enum: OWN_NONE=2'd0, OWN_ENG=2'd1, OWN_HOST=2'd2.
- Single module; no sub-module warranted. The counter and read-tag register are inline.

Test Plan:
- Engine-only read: SRAM[0x045]=0x03, eng_req with eng_wen=1, eng_a=0x045 -> eng_gnt same cycle, sram_a=0x045; next cycle eng_qv=1, eng_q=0x03, host_qv=0.
- Simultaneous single-cycle reqs (eng write 0x07 to 0x010, host read 0x010) -> cycle0 eng_gnt, sram_wen=0; cycle1 host_gnt; cycle2 host_qv=1, host_q=0x07.
- Starvation with STARVE_MAX=8: engine requests every cycle, host_req held from cycle0 -> host_gnt first at cycle8 with eng_gnt=0; eng_gnt resumes cycle9; starve_cnt=0 after cycle8.
- Lock: eng_lock=1 for 20 cycles with continuous eng_req, host waiting -> no host_gnt during the lock; host_gnt in the first cycle eng_lock=0.
- Alternating reads (eng 0x001, host 0x002, eng 0x003; host waiting so each is forced/idle) -> qv pulses follow grant order one cycle late, with no cross-steering.
- Reset asserted the cycle after an eng read grant -> eng_qv stays 0 through and after reset; first post-reset request is granted normally.

Source files
------------

// File: rtl/cle_pkg.sv
// rtl/cle_pkg.sv - shared widths and read-owner tags for the label SRAM path
package cle_pkg;

  localparam int CLE_AW = 10;
  localparam int CLE_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ENG  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/cle_sram_arb.sv
// rtl/cle_sram_arb.sv - engine-priority arbiter for the label SRAM with host starvation override
module cle_sram_arb
  import cle_pkg::*;
#(
  parameter int AW         = CLE_AW,
  parameter int DW         = CLE_DW,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          eng_req,
  input  logic          eng_wen,
  input  logic          eng_lock,
  input  logic [AW-1:0] eng_a,
  input  logic [DW-1:0] eng_d,
  output logic          eng_gnt,
  output logic [DW-1:0] eng_q,
  output logic          eng_qv,
  input  logic          host_req,
  input  logic          host_wen,
  input  logic [AW-1:0] host_a,
  input  logic [DW-1:0] host_d,
  output logic          host_gnt,
  output logic [DW-1:0] host_q,
  output logic          host_qv,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  input  logic [DW-1:0] sram_q
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic          force_host;

  // Grants are held low during reset so nothing reaches the macro.
  always_comb begin
    force_host = host_req && (starve_cnt_q == STARVE_LIM) && !(eng_req && eng_lock);
    host_gnt   = !reset && host_req && (!eng_req || force_host);
    eng_gnt    = !reset && eng_req && !host_gnt;
  end

  always_comb begin
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = 1'b1;
    if (eng_gnt) begin
      sram_a   = eng_a;
      sram_d   = eng_d;
      sram_wen = eng_wen;
    end else if (host_gnt) begin
      sram_a   = host_a;
      sram_d   = host_d;
      sram_wen = host_wen;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!host_req || host_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    rd_owner_d = OWN_NONE;
    if (eng_gnt && eng_wen) begin
      rd_owner_d = OWN_ENG;
    end else if (host_gnt && host_wen) begin
      rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read data is a straight passthrough; only the valids are steered.
  assign eng_q   = sram_q;
  assign host_q  = sram_q;
  assign eng_qv  = (rd_owner_q == OWN_ENG);
  assign host_qv = (rd_owner_q == OWN_HOST);

endmodule

// File: tb/tb_cle_sram_arb.sv
// tb/tb_cle_sram_arb.sv - directed self-checking bench for cle_sram_arb
module tb_cle_sram_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       eng_req, eng_wen, eng_lock;
  logic [9:0] eng_a;
  logic [7:0] eng_d;
  logic       eng_gnt, eng_qv;
  logic [7:0] eng_q;
  logic       host_req, host_wen;
  logic [9:0] host_a;
  logic [7:0] host_d;
  logic       host_gnt, host_qv;
  logic [7:0] host_q;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic [7:0] sram_q;

  logic [7:0] mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;
  int lock_hgnt;

  always #5 clk = ~clk;

  // Behavioural single-port macro: read-first, data one cycle after address.
  always @(posedge clk) begin
    if (!sram_wen) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  cle_sram_arb #(.AW(10), .DW(8), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .eng_req(eng_req), .eng_wen(eng_wen), .eng_lock(eng_lock),
    .eng_a(eng_a), .eng_d(eng_d), .eng_gnt(eng_gnt), .eng_q(eng_q), .eng_qv(eng_qv),
    .host_req(host_req), .host_wen(host_wen), .host_a(host_a), .host_d(host_d),
    .host_gnt(host_gnt), .host_q(host_q), .host_qv(host_qv),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    eng_req = 0; eng_wen = 1; eng_lock = 0; eng_a = '0; eng_d = '0;
    host_req = 0; host_wen = 1; host_a = '0; host_d = '0;
  endtask

  initial begin
    mem[10'h045] = 8'h03;
    mem[10'h001] = 8'h11;
    mem[10'h002] = 8'h22;
    mem[10'h003] = 8'h33;
    idle();
    reset = 1;
    eng_req = 1; eng_wen = 0; host_req = 1; host_wen = 0;
    #3;
    chk("rst_eng_gnt", eng_gnt, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_sram_wen", sram_wen, 1);
    chk("rst_eng_qv", eng_qv, 0);
    chk("rst_host_qv", host_qv, 0);
    tick(); tick();
    idle();
    reset = 0;
    chk("rst_cnt", dut.starve_cnt_q, 0);

    // Engine-only read
    eng_req = 1; eng_wen = 1; eng_a = 10'h045;
    #1;
    chk("t1_eng_gnt", eng_gnt, 1);
    chk("t1_host_gnt", host_gnt, 0);
    chk("t1_sram_a", sram_a, 10'h045);
    chk("t1_sram_wen", sram_wen, 1);
    tick(); idle(); #1;
    chk("t1_eng_qv", eng_qv, 1);
    chk("t1_eng_q", eng_q, 8'h03);
    chk("t1_host_qv", host_qv, 0);
    tick();

    // Simultaneous: engine write wins, host read follows and sees the new data
    eng_req = 1; eng_wen = 0; eng_a = 10'h010; eng_d = 8'h07;
    host_req = 1; host_wen = 1; host_a = 10'h010;
    #1;
    chk("t2_eng_gnt", eng_gnt, 1);
    chk("t2_host_gnt0", host_gnt, 0);
    chk("t2_sram_wen", sram_wen, 0);
    chk("t2_sram_d", sram_d, 8'h07);
    tick(); eng_req = 0; eng_wen = 1; #1;
    chk("t2_host_gnt1", host_gnt, 1);
    chk("t2_sram_a1", sram_a, 10'h010);
    chk("t2_no_wr_qv", eng_qv, 0);
    tick(); host_req = 0; #1;
    chk("t2_host_qv", host_qv, 1);
    chk("t2_host_q", host_q, 8'h07);
    chk("t2_eng_qv", eng_qv, 0);
    chk("t2_cnt", dut.starve_cnt_q, 0);
    tick();

    // Starvation override on the 9th waiting cycle
    eng_req = 1; eng_wen = 1; eng_a = 10'h100;
    host_wen = 1; host_a = 10'h200;
    for (int c = 0; c < 10; c++) begin
      host_req = (c <= 8);
      #1;
      if (c < 8) begin
        chk($sformatf("t3_eng_gnt_c%0d", c), eng_gnt, 1);
        chk($sformatf("t3_host_gnt_c%0d", c), host_gnt, 0);
      end else if (c == 8) begin
        chk("t3_host_gnt_c8", host_gnt, 1);
        chk("t3_eng_gnt_c8", eng_gnt, 0);
        chk("t3_sram_a_c8", sram_a, 10'h200);
      end else begin
        chk("t3_eng_gnt_c9", eng_gnt, 1);
        chk("t3_cnt_c9", dut.starve_cnt_q, 0);
        chk("t3_host_qv_c9", host_qv, 1);
        chk("t3_eng_qv_c9", eng_qv, 0);
      end
      tick();
    end
    idle(); tick();

    // Lock holds off the override until it drops
    eng_req = 1; eng_lock = 1; eng_wen = 1; eng_a = 10'h300;
    host_req = 1; host_wen = 1; host_a = 10'h301;
    lock_hgnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (host_gnt) lock_hgnt++;
      tick();
    end
    chk("t4_lock_host_gnts", lock_hgnt, 0);
    chk("t4_cnt_sat", dut.starve_cnt_q, 8);
    eng_lock = 0; #1;
    chk("t4_host_gnt_unlock", host_gnt, 1);
    chk("t4_eng_gnt_unlock", eng_gnt, 0);
    tick(); host_req = 0; #1;
    chk("t4_eng_resume", eng_gnt, 1);
    tick(); idle(); tick();

    // Alternating single reads: qv follows grant order one cycle late
    eng_req = 1; eng_a = 10'h001; #1;
    chk("t5_c0_eng_gnt", eng_gnt, 1);
    tick(); idle(); host_req = 1; host_a = 10'h002; #1;
    chk("t5_c1_host_gnt", host_gnt, 1);
    chk("t5_c1_eng_qv", eng_qv, 1);
    chk("t5_c1_eng_q", eng_q, 8'h11);
    chk("t5_c1_host_qv", host_qv, 0);
    tick(); idle(); eng_req = 1; eng_a = 10'h003; #1;
    chk("t5_c2_eng_gnt", eng_gnt, 1);
    chk("t5_c2_host_qv", host_qv, 1);
    chk("t5_c2_host_q", host_q, 8'h22);
    chk("t5_c2_eng_qv", eng_qv, 0);
    tick(); idle(); #1;
    chk("t5_c3_eng_qv", eng_qv, 1);
    chk("t5_c3_eng_q", eng_q, 8'h33);
    chk("t5_c3_host_qv", host_qv, 0);
    tick();
    chk("t5_c4_eng_qv", eng_qv, 0);
    chk("t5_c4_host_qv", host_qv, 0);

    // Reset in the cycle after an engine read grant
    eng_req = 1; eng_a = 10'h045; #1;
    chk("t6_eng_gnt", eng_gnt, 1);
    tick(); idle(); reset = 1; #1;
    chk("t6_qv_in_rst", eng_qv, 0);
    tick();
    chk("t6_qv_in_rst2", eng_qv, 0);
    reset = 0; #1;
    chk("t6_qv_after_rst", eng_qv, 0);
    tick();
    chk("t6_qv_after_rst2", eng_qv, 0);
    eng_req = 1; eng_a = 10'h010; #1;
    chk("t6_post_gnt", eng_gnt, 1);
    tick(); idle(); #1;
    chk("t6_post_qv", eng_qv, 1);
    chk("t6_post_q", eng_q, 8'h07);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
